// File: rtl/serial_compare_if.sv
// serial_compare_if: operand/result bundle for the serial magnitude comparator.
//   start      request a compare (driven by master)
//   a, b       WIDTH-bit operands (driven by master)
//   busy       compare in progress (driven by slave)
//   done       one-cycle completion pulse (driven by slave)
//   eq, gt, lt unsigned compare result, held until the next accepted start
interface serial_compare_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;

   modport master (
      output start, a, b,
      input  busy, done, eq, gt, lt
   );

   modport slave (
      input  start, a, b,
      output busy, done, eq, gt, lt
   );
endinterface

// File: rtl/serial_compare.sv
// serial_compare: sequential WIDTH-bit unsigned magnitude comparator.
// Captures a/b on an accepted start, then walks the operands MSB-first one
// bit per clock through a single compare1b equality cell. The first
// mismatching bit decides gt/lt; no mismatch means eq.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   serial_compare_if.slave (start, a, b in; busy, done, eq, gt, lt out)
//
// Build option:
//   SERIAL_COMPARE_EARLY_EXIT_EN  when defined, the first mismatching bit
//   finishes the compare on that same edge (latency WIDTH-k for a mismatch
//   at bit k). When undefined, every compare takes WIDTH cycles.
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | waiting for start; results held
// S_RUN  | comparing one bit pair per clock, MSB first

module compare1b (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = ~(a ^ b);
endmodule

module serial_compare #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic            clk,
   input  logic            rst,
   serial_compare_if.slave bus
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [CW-1:0]    cnt;
   logic             mism;
   logic             agt;
   logic             busy_ff;
   logic             done_ff;
   logic             eq_ff;
   logic             gt_ff;
   logic             lt_ff;

   logic             bit_eq;
   logic             mism_now;
   logic             agt_now;
   logic             last;

   compare1b u_cmp (
      .a (sa[WIDTH-1]),
      .b (sb[WIDTH-1]),
      .y (bit_eq)
   );

   // Result including the bit under evaluation this cycle; once a mismatch
   // is latched, later bits cannot change the direction.
   always_comb begin
      mism_now = mism | ~bit_eq;
      agt_now  = mism ? agt : sa[WIDTH-1];
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
      // Exiting on the first mismatch means mism is never set on entry here.
      last     = (cnt == '0) | ~bit_eq;
`else
      last     = (cnt == '0);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         sa      <= '0;
         sb      <= '0;
         cnt     <= '0;
         mism    <= 1'b0;
         agt     <= 1'b0;
         busy_ff <= 1'b0;
         done_ff <= 1'b0;
         eq_ff   <= 1'b0;
         gt_ff   <= 1'b0;
         lt_ff   <= 1'b0;
      end else begin
         done_ff <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  sa      <= bus.a;
                  sb      <= bus.b;
                  cnt     <= CW'(WIDTH - 1);
                  mism    <= 1'b0;
                  agt     <= 1'b0;
                  busy_ff <= 1'b1;
                  eq_ff   <= 1'b0;
                  gt_ff   <= 1'b0;
                  lt_ff   <= 1'b0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               mism <= mism_now;
               agt  <= agt_now;
               sa   <= sa << 1;
               sb   <= sb << 1;
               cnt  <= cnt - 1'b1;
               if (last) begin
                  state   <= S_IDLE;
                  busy_ff <= 1'b0;
                  done_ff <= 1'b1;
                  eq_ff   <= ~mism_now;
                  gt_ff   <= mism_now & agt_now;
                  lt_ff   <= mism_now & ~agt_now;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_ff;
   assign bus.done = done_ff;
   assign bus.eq   = eq_ff;
   assign bus.gt   = gt_ff;
   assign bus.lt   = lt_ff;

endmodule

// File: tb/tb_serial_compare.sv
// Scoreboard bench for serial_compare. The driver issues compares and pushes
// the expected result and completion time; a negedge monitor checks busy,
// done timing and eq/gt/lt every cycle against that model.
module tb_serial_compare;
   localparam int W = 8;

   typedef struct {
      longint     t;
      logic [2:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   serial_compare_if #(.WIDTH(W)) bus ();

   serial_compare #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   exp_t       sb_q[$];
   longint     busy_from = 0;
   longint     busy_to   = 0;
   longint     next_free = 0;
   longint     tn = 0;
   logic [2:0] res_hold = 3'b000;
   bit         mon_en = 0;

   task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   // Reference: plain unsigned comparison; result order {eq,gt,lt}.
   function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
      if (x == y) return 3'b100;
      else if (x > y) return 3'b010;
      else return 3'b001;
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
      for (int k = W - 1; k >= 0; k--)
         if (x[k] != y[k]) return W - k;
`endif
      return W;
   endfunction

   // Monitor: samples on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         longint     t;
         logic       eb;
         logic       ed;
         logic [2:0] er;
         t  = $time;
         eb = (t > busy_from) && (t <= busy_to);
         chk("busy", {2'b00, bus.busy}, {2'b00, eb});
         ed = (sb_q.size() > 0) && (sb_q[0].t == t);
         chk("done", {2'b00, bus.done}, {2'b00, ed});
         if (ed) begin
            res_hold = sb_q[0].res;
            void'(sb_q.pop_front());
         end else if (sb_q.size() > 0 && t > sb_q[0].t) begin
            void'(sb_q.pop_front());
         end
         er = eb ? 3'b000 : res_hold;
         chk("result", {bus.eq, bus.gt, bus.lt}, er);
      end
   end

   task automatic step();
      @(negedge clk);
      tn = $time;
      #1;
   endtask

   task automatic do_reset(input int n, input logic hold_start);
      rst       = 1'b1;
      bus.start = hold_start;
      bus.a     = 8'hFF;
      bus.b     = 8'h00;
      sb_q.delete();
      busy_from = 0;
      busy_to   = 0;
      next_free = 0;
      res_hold  = 3'b000;
      mon_en    = 1;
      repeat (n) step();
      rst       = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit ign);
      int   l;
      exp_t e;
      int   guard;
      guard = 0;
      while (tn < next_free && guard < 100) begin
         step();
         guard++;
      end
      l         = ref_lat(x, y);
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      e.t       = tn + 10 * (l + 1);
      e.res     = ref_res(x, y);
      sb_q.push_back(e);
      busy_from = tn;
      busy_to   = tn + 10 * l;
      next_free = tn + 10 * (l + 1);
      step();
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
      if (ign && l >= 2) begin
         bus.a     = 8'h00;
         bus.b     = 8'hFF;
         bus.start = 1'b1;
         step();
         bus.start = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      int           guard;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      step();
      do_reset(2, 1'b1);
      step();

      issue(8'hA5, 8'hA5, 0);
      issue(8'h80, 8'h7F, 0);
      issue(8'h12, 8'h13, 0);
      issue(8'h35, 8'h34, 1);
      issue(8'hC3, 8'hC3, 1);
      issue(8'h01, 8'h00, 0);

      issue(8'h00, 8'h01, 0);
      repeat (3) step();
      do_reset(1, 1'b0);
      step();
      issue(8'h00, 8'h01, 0);

      for (int i = 0; i < 40; i++) begin
         x = $urandom();
         case ($urandom_range(0, 3))
            0: y = x;
            1: y = x ^ (8'h01 << $urandom_range(0, W - 1));
            default: y = $urandom();
         endcase
         issue(x, y, $urandom_range(0, 2) == 0);
         repeat ($urandom_range(0, 2)) step();
      end

      guard = 0;
      while (sb_q.size() > 0 && guard < 50) begin
         step();
         guard++;
      end
      checks++;
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d compares never completed, expected 0", sb_q.size());
      end
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_compare.md
Name: serial_compare

Overview:
- Sequential N-bit magnitude comparator built on the existing 1-bit equality cell `compare1b` (y=1 when a==b).
- Loads two WIDTH-bit operands and walks them MSB-first, one bit per clock, feeding each bit pair into one `compare1b` instance.
- Reports eq/gt/lt with a done pulse.
- This is the upstream sequencer for the 1-bit cell and the next step in the comparator series.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CW, $clog2(WIDTH), width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- busy  out  1  high while bits are being compared.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- eq  out  1  A==B.
- gt  out  1  A>B, unsigned.
- lt  out  1  A<B, unsigned.

Behaviour:
- Reset: all registered at rst=1 on a clk edge.
  - state=IDLE; busy=0, done=0, eq=0, gt=0, lt=0.
  - Shift registers and counter cleared.
  - Reset mid-RUN aborts the compare; no done pulse is issued.
- States:
  - IDLE: when start=1 at edge t0:
    - load sa<=a, sb<=b, cnt<=WIDTH-1, mism<=0.
    - busy<=1, done<=0.
    - eq/gt/lt cleared to 0.
    - go to RUN.
  - RUN: each edge, `compare1b` evaluates sa[WIDTH-1] vs sb[WIDTH-1].
    - On the first mismatch (y=0), mism<=1 and agt<=sa[WIDTH-1]. Later bits never alter mism or agt.
    - Shift sa and sb left by 1; cnt<=cnt-1.
    - The edge processing cnt==0 is the last one: state<=IDLE, busy<=0, done<=1.
    - On that edge: eq<=~mism_final, gt<=mism_final&agt, lt<=mism_final&~agt, where mism_final includes the current bit.
- done is high for exactly one cycle; eq/gt/lt hold until the next accepted start.
- Latency: start sampled at edge t0 gives busy high in cycles t0+1..t0+WIDTH and done high in the cycle after edge t0+WIDTH.
- start while busy=1 is ignored; no queueing.
- start=1 in the same cycle done=1 is accepted, because state is already IDLE. done drops and busy rises on the next edge.
- a and b may change freely after the start edge.
- Exactly one of eq/gt/lt is 1 after any done; all three are 0 while busy.

Optional Feature:
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- Defined: a mismatch at bit k ends RUN on that same edge, with done, busy=0 and results set there. Latency is WIDTH-k cycles; an equal compare still takes WIDTH cycles.
- Undefined: always WIDTH cycles regardless of data; the first-mismatch latch alone determines the result.

Test Plan:
- Reset with rst=1 for 2 cycles, start=1 held -> busy=0, done=0, eq=gt=lt=0 throughout reset.
- WIDTH=8, a=8'hA5, b=8'hA5, start pulse at t0 -> busy high 8 cycles, done at t0+8, eq=1, gt=0, lt=0.
- a=8'h80, b=8'h7F -> gt=1, lt=0, eq=0.
  - Without the macro, done at t0+8.
  - With SERIAL_COMPARE_EARLY_EXIT_EN, done at t0+1.
- a=8'h12, b=8'h13 (LSB-only difference) -> lt=1, done at t0+8 in both builds.
- Protocol: start re-asserted during busy (a=0, b=FF) is ignored and the result reflects the first operands. Back-to-back start on the done cycle is accepted, and the second result follows 8 cycles later.
- rst=1 at the 4th RUN cycle of a=8'h00, b=8'h01 -> no done pulse, busy=0 next cycle, eq=gt=lt=0. A new start then completes normally with lt=1.
